// File: rtl/debug_rom_ctrl.sv
// Purpose: read-only debug ROM behind a req/gnt/rvalid bus; rejects writes, misaligned and out-of-range reads.
// Latency: fixed Latency cycles (1..3) from the accepting edge to rvalid_o, fully pipelined.
// Backpressure: none; gnt_o mirrors req_i, one request accepted per cycle, responses cannot be stalled.
module debug_rom_ctrl #(
    parameter int unsigned              DataWidth = 64,
    parameter int unsigned              RomDepth  = 20,
    parameter int unsigned              Latency   = 1,
    parameter logic [RomDepth*64-1:0]   RomInit   = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [63:0]          addr_i,
    output logic                 gnt_o,
    output logic                 rvalid_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 err_o,
    output logic [7:0]           err_cnt_o
);

    // Byte-offset bits within one data beat: 8-byte beats in 64-bit mode, 4-byte beats in 32-bit mode.
    localparam int unsigned OffBits = (DataWidth == 64) ? 3 : 2;
    // Width of the in-range entry index used to address the table.
    localparam int unsigned IdxW    = (RomDepth > 1) ? $clog2(RomDepth) : 1;

    // Reject illegal parameterisations at elaboration rather than producing a silently broken ROM.
    if (!(DataWidth == 32 || DataWidth == 64)) begin : g_bad_data_width
        $error("debug_rom_ctrl: DataWidth must be 32 or 64");
    end
    if (RomDepth < 1 || RomDepth > 256) begin : g_bad_rom_depth
        $error("debug_rom_ctrl: RomDepth must be in 1..256");
    end
    if (Latency < 1 || Latency > 3) begin : g_bad_latency
        $error("debug_rom_ctrl: Latency must be in 1..3");
    end

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [63:0]     idx_full;
    logic            out_of_range;
    logic            misaligned;
    logic            req_err;
    logic [IdxW-1:0] idx;

    // Index is derived from all 64 address bits so high garbage bits can never alias a valid entry.
    assign idx_full     = addr_i >> 3;
    assign out_of_range = (idx_full >= 64'(RomDepth));
    assign misaligned   = |addr_i[OffBits-1:0];
    // Any combination of faults collapses into a single error response.
    assign req_err      = we_i | out_of_range | misaligned;
    // Park the table index at 0 for out-of-range accesses so the lookup never leaves the table.
    assign idx          = out_of_range ? '0 : idx_full[IdxW-1:0];

    // Requests are never stalled.
    assign gnt_o = req_i;

    // ------------------------------------------------------------------
    // ROM table and lane select
    // ------------------------------------------------------------------
    logic [63:0] rom_tbl [RomDepth];

    for (genvar g = 0; g < int'(RomDepth); g++) begin : g_rom
        assign rom_tbl[g] = RomInit[64*g +: 64];
    end

    logic [63:0]          entry;
    logic [DataWidth-1:0] lane;
    logic [DataWidth-1:0] lookup_dat;

    assign entry = rom_tbl[idx];

    if (DataWidth == 64) begin : g_lane64
        assign lane = entry;
    end else begin : g_lane32
        // Little-endian: the lower word sits at the lower address.
        assign lane = addr_i[2] ? entry[63:32] : entry[31:0];
    end

    // Error responses return zeros so no stale or undefined data reaches the core.
    assign lookup_dat = req_err ? '0 : lane;

    // ------------------------------------------------------------------
    // Response pipeline
    // ------------------------------------------------------------------
    logic                 vld_q [Latency];
    logic                 vld_d [Latency];
    logic                 err_q [Latency];
    logic                 err_d [Latency];
    logic [DataWidth-1:0] dat_q [Latency];
    logic [DataWidth-1:0] dat_d [Latency];
    logic [7:0]           err_cnt_q;
    logic [7:0]           err_cnt_d;

    // Next-state for each stage; data only moves with a valid token so the last stage holds the previous response.
    always_comb begin
        vld_d[0] = req_i;
        err_d[0] = req_i & req_err;
        dat_d[0] = req_i ? lookup_dat : dat_q[0];
        for (int k = 1; k < int'(Latency); k++) begin
            vld_d[k] = vld_q[k-1];
            err_d[k] = err_q[k-1];
            dat_d[k] = vld_q[k-1] ? dat_q[k-1] : dat_q[k];
        end
    end

    // Saturating error counter, advanced once per error response.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (rvalid_o && err_o && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Pipeline and counter registers; reset drops any in-flight request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < int'(Latency); k++) begin
                vld_q[k] <= 1'b0;
                err_q[k] <= 1'b0;
                dat_q[k] <= '0;
            end
            err_cnt_q <= 8'd0;
        end else begin
            for (int k = 0; k < int'(Latency); k++) begin
                vld_q[k] <= vld_d[k];
                err_q[k] <= err_d[k];
                dat_q[k] <= dat_d[k];
            end
            err_cnt_q <= err_cnt_d;
        end
    end

    assign rvalid_o  = vld_q[Latency-1];
    // Error bit is only ever set alongside a valid token, so it reads 0 between responses.
    assign err_o     = err_q[Latency-1];
    assign rdata_o   = dat_q[Latency-1];
    assign err_cnt_o = err_cnt_q;

endmodule
